// File: rtl/exception_ctrl_if.sv
// Exception sequencer bus.
// It groups the control-unit flags, the PC and the memory data that flow into
// the sequencer, together with the EPC, PC and memory strobes it drives back.
//   slave  : the sequencer side. Flags, PC and Mem_Data are inputs; strobes and values are outputs.
//   master : the control-unit/datapath side. It has the opposite directions.
interface exception_ctrl_if;
  logic        AllowException;
  logic        OPCode_Error;
  logic        Overflow;
  logic        Div_Zero;
  logic [31:0] PC;
  logic [31:0] Mem_Data;
  logic        Exception_Signal;
  logic        EPC_Load;
  logic [31:0] EPC_Value;
  logic        Exc_Mem_Read;
  logic [31:0] Exc_Mem_Addr;
  logic        PC_Load;
  logic [31:0] PC_New;
  logic [1:0]  Exc_Cause;

  modport slave (
    input  AllowException, OPCode_Error, Overflow, Div_Zero, PC, Mem_Data,
    output Exception_Signal, EPC_Load, EPC_Value, Exc_Mem_Read, Exc_Mem_Addr,
           PC_Load, PC_New, Exc_Cause
  );

  modport master (
    output AllowException, OPCode_Error, Overflow, Div_Zero, PC, Mem_Data,
    input  Exception_Signal, EPC_Load, EPC_Value, Exc_Mem_Read, Exc_Mem_Addr,
           PC_Load, PC_New, Exc_Cause
  );
endinterface

// File: rtl/exception_ctrl.sv
// Exception sequencer for the multicycle control unit.
// When an exception is raised, the sequencer takes over the datapath. It writes
// PC-4 into EPC, fetches the handler byte from the vector for the cause, and
// loads PC with that byte zero-extended. It then hands control back.
// Ports:
//   Clock : rising-edge clock.
//   Reset : asynchronous, active-high. It aborts any sequence that is in progress.
//   io    : exception_ctrl_if.slave. It carries the flags, PC and Mem_Data in,
//           and the Exception_Signal, EPC/PC strobes, memory read, and cause out.
module exception_ctrl #(
  parameter int MEM_LATENCY = 1,
  parameter int VEC_OPCODE  = 253,
  parameter int VEC_OVF     = 254,
  parameter int VEC_DIVZ    = 255
) (
  input logic             Clock,
  input logic             Reset,
  exception_ctrl_if.slave io
);
  typedef enum logic [1:0] {IDLE, S_EPC, S_WAIT, S_LOAD} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_LATENCY - 1);

  state_t      state, nxt;
  logic [1:0]  cause, trig_cause;
  logic [31:0] epc_q, pc_new_q;
  logic [3:0]  cnt;
  logic        unused_hi;

  // Only the low byte of the vector word is meaningful.
  assign unused_hi = ^io.Mem_Data[31:8];

  // The opcode error is not gated by AllowException. It also wins over the other flags.
  always_comb begin
    trig_cause = 2'b00;
    if (io.OPCode_Error)                          trig_cause = 2'b01;
    else if (io.Div_Zero && io.AllowException)    trig_cause = 2'b11;
    else if (io.Overflow && io.AllowException)    trig_cause = 2'b10;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (trig_cause != 2'b00) nxt = S_EPC;
      S_EPC:   nxt = S_WAIT;
      S_WAIT:  if (cnt == WAIT_LAST) nxt = S_LOAD;
      S_LOAD:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cause    <= 2'b00;
      epc_q    <= '0;
      pc_new_q <= '0;
      cnt      <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (trig_cause != 2'b00) begin
          cause <= trig_cause;
          epc_q <= io.PC - 32'd4;
        end
        S_EPC:  cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          if (cnt == WAIT_LAST) pc_new_q <= {24'b0, io.Mem_Data[7:0]};
        end
        default: ;
      endcase
    end
  end

  // The outputs are decoded from the registered state only.
  always_comb begin
    io.Exception_Signal = (state != IDLE);
    io.EPC_Load         = (state == S_EPC);
    io.Exc_Mem_Read     = (state == S_WAIT);
    io.PC_Load          = (state == S_LOAD);
    io.Exc_Mem_Addr     = '0;
    if (state == S_WAIT) begin
      case (cause)
        2'b01:   io.Exc_Mem_Addr = 32'(VEC_OPCODE);
        2'b10:   io.Exc_Mem_Addr = 32'(VEC_OVF);
        2'b11:   io.Exc_Mem_Addr = 32'(VEC_DIVZ);
        default: io.Exc_Mem_Addr = '0;
      endcase
    end
    io.EPC_Value = epc_q;
    io.PC_New    = pc_new_q;
    io.Exc_Cause = cause;
  end
endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 Clock = ~Clock;

  exception_ctrl_if if1 ();
  exception_ctrl_if if3 ();

  exception_ctrl #(.MEM_LATENCY(1)) dut1 (.Clock(Clock), .Reset(Reset), .io(if1.slave));
  exception_ctrl #(.MEM_LATENCY(3)) dut3 (.Clock(Clock), .Reset(Reset), .io(if3.slave));

  // Inputs are driven and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge Clock);
  endtask

  // Packs {Exception_Signal, EPC_Load, Exc_Mem_Read, PC_Load}.
  function automatic logic [3:0] ctl1();
    return {if1.Exception_Signal, if1.EPC_Load, if1.Exc_Mem_Read, if1.PC_Load};
  endfunction
  function automatic logic [3:0] ctl3();
    return {if3.Exception_Signal, if3.EPC_Load, if3.Exc_Mem_Read, if3.PC_Load};
  endfunction

  function automatic logic [164:0] all1();
    return {ctl1(), if1.EPC_Value, if1.Exc_Mem_Addr, if1.PC_New, if1.Exc_Cause,
            if1.Mem_Data[31:0] & 32'h0, 1'b0};
  endfunction
  function automatic logic [164:0] all3();
    return {ctl3(), if3.EPC_Value, if3.Exc_Mem_Addr, if3.PC_New, if3.Exc_Cause,
            if3.Mem_Data[31:0] & 32'h0, 1'b0};
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (all1() !== '0) begin
      errors++; $display("FAIL reset_dut1: got %h want 0", all1());
    end
    checks++;
    if (all3() !== '0) begin
      errors++; $display("FAIL reset_dut3: got %h want 0", all3());
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (ctl1() !== 4'b0000) begin
      errors++; $display("FAIL post_reset_idle: got %b want 0000", ctl1());
    end
  endtask

  // Opcode error with AllowException low. The sequence lasts three cycles.
  task automatic test_opcode();
    logic [3:0] exp_ctl [4] = '{4'b1100, 4'b1010, 4'b1001, 4'b0000};
    int hi = 0;
    if1.OPCode_Error = 1'b1; if1.AllowException = 1'b0;
    if1.PC = 32'h20; if1.Mem_Data = 32'h000000A7;
    for (int c = 0; c < 4; c++) begin
      tick();
      if1.OPCode_Error = 1'b0;
      if (if1.Exception_Signal === 1'b1) hi++;
      checks++;
      if (ctl1() !== exp_ctl[c]) begin
        errors++; $display("FAIL opc_ctl c%0d: got %b want %b", c, ctl1(), exp_ctl[c]);
      end
      if (c == 0) begin
        checks++;
        if (if1.EPC_Value !== 32'h1C || if1.Exc_Cause !== 2'b01) begin
          errors++; $display("FAIL opc_epc: got %h/%b want 0000001c/01", if1.EPC_Value, if1.Exc_Cause);
        end
      end
      if (c == 1) begin
        checks++;
        if (if1.Exc_Mem_Addr !== 32'd253) begin
          errors++; $display("FAIL opc_addr: got %0d want 253", if1.Exc_Mem_Addr);
        end
      end
      if (c == 2) begin
        checks++;
        if (if1.PC_New !== 32'hA7 || if1.Exc_Mem_Addr !== 32'd0) begin
          errors++; $display("FAIL opc_pcnew: got %h addr %0d want 000000a7 addr 0", if1.PC_New, if1.Exc_Mem_Addr);
        end
      end
    end
    checks++;
    if (hi !== 3) begin
      errors++; $display("FAIL opc_exc_len: got %0d want 3", hi);
    end
  endtask

  task automatic test_overflow();
    if1.Overflow = 1'b1; if1.AllowException = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (ctl1() !== 4'b0000 || if1.Exc_Cause !== 2'b01) begin
        errors++; $display("FAIL ovf_gated c%0d: got %b cause %b want 0000 cause 01", c, ctl1(), if1.Exc_Cause);
      end
    end
    if1.AllowException = 1'b1;
    tick();
    if1.Overflow = 1'b0; if1.AllowException = 1'b0;
    checks++;
    if (if1.Exc_Cause !== 2'b10 || ctl1() !== 4'b1100) begin
      errors++; $display("FAIL ovf_cause: got %b ctl %b want 10 ctl 1100", if1.Exc_Cause, ctl1());
    end
    tick();
    checks++;
    if (if1.Exc_Mem_Addr !== 32'd254) begin
      errors++; $display("FAIL ovf_addr: got %0d want 254", if1.Exc_Mem_Addr);
    end
    tick(); tick();
  endtask

  task automatic test_priority();
    if1.OPCode_Error = 1'b1; if1.Div_Zero = 1'b1; if1.Overflow = 1'b1;
    if1.AllowException = 1'b1; if1.PC = 32'h100;
    tick();
    if1.OPCode_Error = 1'b0; if1.Div_Zero = 1'b0; if1.Overflow = 1'b0;
    checks++;
    if (if1.Exc_Cause !== 2'b01 || if1.EPC_Value !== 32'hFC) begin
      errors++; $display("FAIL prio_all: got %b epc %h want 01 epc 000000fc", if1.Exc_Cause, if1.EPC_Value);
    end
    tick(); tick(); tick();
    if1.Div_Zero = 1'b1; if1.Overflow = 1'b1;
    tick();
    if1.Div_Zero = 1'b0; if1.Overflow = 1'b0; if1.AllowException = 1'b0;
    checks++;
    if (if1.Exc_Cause !== 2'b11) begin
      errors++; $display("FAIL prio_dz: got %b want 11", if1.Exc_Cause);
    end
    tick();
    checks++;
    if (if1.Exc_Mem_Addr !== 32'd255) begin
      errors++; $display("FAIL prio_dz_addr: got %0d want 255", if1.Exc_Mem_Addr);
    end
    tick(); tick();
  endtask

  task automatic test_pc_zero();
    if1.OPCode_Error = 1'b1; if1.PC = 32'h0;
    tick();
    if1.OPCode_Error = 1'b0;
    checks++;
    if (if1.EPC_Value !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL pc_zero: got %h want fffffffc", if1.EPC_Value);
    end
    tick(); tick(); tick();
  endtask

  // MEM_LATENCY=3. The trigger stays asserted for the whole sequence.
  task automatic test_latency3();
    logic [3:0] exp_ctl [6] = '{4'b1100, 4'b1010, 4'b1010, 4'b1010, 4'b1001, 4'b0000};
    if3.Overflow = 1'b1; if3.AllowException = 1'b1;
    if3.PC = 32'h40; if3.Mem_Data = 32'hFFFFFF42;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (ctl3() !== exp_ctl[c]) begin
        errors++; $display("FAIL lat3_ctl c%0d: got %b want %b", c, ctl3(), exp_ctl[c]);
      end
      if (c == 2) begin
        checks++;
        if (if3.Exc_Mem_Addr !== 32'd254 || if3.EPC_Value !== 32'h3C) begin
          errors++; $display("FAIL lat3_addr: got %0d epc %h want 254 epc 0000003c", if3.Exc_Mem_Addr, if3.EPC_Value);
        end
      end
      if (c == 4) begin
        checks++;
        if (if3.PC_New !== 32'h42) begin
          errors++; $display("FAIL lat3_pcnew: got %h want 00000042", if3.PC_New);
        end
      end
    end
    if3.Overflow = 1'b0; if3.AllowException = 1'b0;
    tick();
  endtask

  task automatic test_reset_midseq();
    int pl = 0;
    if3.Div_Zero = 1'b1; if3.AllowException = 1'b1; if3.PC = 32'h80;
    tick();
    if3.Div_Zero = 1'b0; if3.AllowException = 1'b0;
    tick();
    checks++;
    if (ctl3() !== 4'b1010) begin
      errors++; $display("FAIL midseq_wait: got %b want 1010", ctl3());
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (all3() !== '0) begin
      errors++; $display("FAIL midseq_reset_zero: got %h want 0", all3());
    end
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (if3.PC_Load !== 1'b0 || if3.Exception_Signal !== 1'b0) pl++;
    end
    checks++;
    if (pl !== 0) begin
      errors++; $display("FAIL midseq_no_pcload: got %0d active cycles want 0", pl);
    end
    if3.OPCode_Error = 1'b1; if3.PC = 32'h44; if3.Mem_Data = 32'h00000055;
    tick();
    if3.OPCode_Error = 1'b0;
    checks++;
    if (ctl3() !== 4'b1100 || if3.EPC_Value !== 32'h40 || if3.Exc_Cause !== 2'b01) begin
      errors++; $display("FAIL fresh_epc: got %b epc %h cause %b want 1100 epc 00000040 cause 01", ctl3(), if3.EPC_Value, if3.Exc_Cause);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (ctl3() !== 4'b1001 || if3.PC_New !== 32'h55) begin
      errors++; $display("FAIL fresh_pcload: got %b pcnew %h want 1001 pcnew 00000055", ctl3(), if3.PC_New);
    end
    tick();
    checks++;
    if (ctl3() !== 4'b0000) begin
      errors++; $display("FAIL fresh_idle: got %b want 0000", ctl3());
    end
  endtask

  initial begin
    if1.AllowException = 0; if1.OPCode_Error = 0; if1.Overflow = 0; if1.Div_Zero = 0;
    if1.PC = 0; if1.Mem_Data = 0;
    if3.AllowException = 0; if3.OPCode_Error = 0; if3.Overflow = 0; if3.Div_Zero = 0;
    if3.PC = 0; if3.Mem_Data = 0;
    test_reset();
    test_opcode();
    test_overflow();
    test_priority();
    test_pc_zero();
    test_latency3();
    test_reset_midseq();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
